// File: rtl/secure_storage_arbiter.sv
// Round-robin arbiter in front of a single secure storage register.
// The first writer becomes owner; only the owner may read, overwrite or release (scrub).
module secure_storage_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         store_data_in,
  output logic                      store_data_valid,
  input  logic [DATA_W-1:0]         store_data_out,
  input  logic                      store_data_ready,
  output logic                      owner_valid,
  output logic [ID_W-1:0]           owner_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   sel;
  logic              op_write;
  logic              op_release;
  logic              op_read;
  logic              err_q;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [1:0]        pick_op;
  logic [DATA_W-1:0] pick_wdata;
  logic              is_owner;
  logic              write_ok;
  logic              release_ok;
  logic              read_ok;

  // Two passes give the wrap-around search: first from ptr upward, then from 0.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    pick_op    = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found      = 1'b1;
        pick       = ID_W'(i);
        pick_op    = req_op[2*i +: 2];
        pick_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found      = 1'b1;
        pick       = ID_W'(i);
        pick_op    = req_op[2*i +: 2];
        pick_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    is_owner   = owner_valid && (owner_id == pick);
    write_ok   = (pick_op == OP_WRITE) && (!owner_valid || is_owner);
    release_ok = (pick_op == OP_RELEASE) && is_owner;
    read_ok    = (pick_op == OP_READ) && is_owner;
  end

  // The access decision is made at the selection edge so that gnt and the
  // storage strobe appear together as registered outputs in the GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= '0;
      sel              <= '0;
      op_write         <= 1'b0;
      op_release       <= 1'b0;
      op_read          <= 1'b0;
      err_q            <= 1'b0;
      gnt              <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_data         <= '0;
      rsp_err          <= 1'b0;
      store_data_in    <= '0;
      store_data_valid <= 1'b0;
      owner_valid      <= 1'b0;
      owner_id         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel              <= pick;
            gnt              <= NUM_REQ'(1) << pick;
            op_write         <= write_ok;
            op_release       <= release_ok;
            op_read          <= read_ok;
            err_q            <= !(write_ok || release_ok || read_ok);
            store_data_valid <= write_ok || release_ok;
            store_data_in    <= write_ok ? pick_wdata : '0;
            state            <= GRANT;
          end
        end
        GRANT: begin
          gnt              <= '0;
          store_data_valid <= 1'b0;
          store_data_in    <= '0;
          ptr              <= (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
          if (op_write) begin
            owner_valid <= 1'b1;
            owner_id    <= sel;
          end
          if (op_release) begin
            owner_valid <= 1'b0;
            owner_id    <= '0;
          end
          // Only one op is in flight, so storage cannot change for a read between GRANT and RESP.
          rsp_valid <= 1'b1;
          rsp_id    <= sel;
          rsp_err   <= err_q;
          rsp_data  <= (op_read && store_data_ready) ? store_data_out : '0;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_id    <= '0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_storage_arbiter.sv
// Directed bench for secure_storage_arbiter with an ownership model and a response scoreboard.
module tb_secure_storage_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  store_data_in;
  logic        store_data_valid;
  logic [7:0]  store_data_out;
  logic        store_data_ready;
  logic        owner_valid;
  logic [1:0]  owner_id;

  typedef struct {
    logic [1:0] id;
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       m_owner_valid;
  logic [1:0] m_owner_id;
  logic [7:0] m_mem;
  logic       m_ready;

  secure_storage_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_op(req_op),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .store_data_in(store_data_in),
    .store_data_valid(store_data_valid),
    .store_data_out(store_data_out),
    .store_data_ready(store_data_ready),
    .owner_valid(owner_valid),
    .owner_id(owner_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the storage register the arbiter drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_data_out   <= '0;
      store_data_ready <= 1'b0;
    end else if (store_data_valid) begin
      store_data_out   <= store_data_in;
      store_data_ready <= 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner_valid = 1'b0;
    m_owner_id    = '0;
    m_mem         = '0;
    m_ready       = 1'b0;
  endtask

  // Applies the ownership rules to one op, pushes the expected response and returns the expected strobe.
  task automatic predict(input int id, input logic [1:0] op, input logic [7:0] wd,
                         output logic exp_strobe, output logic [7:0] exp_din);
    exp_t e;
    logic is_owner;
    is_owner   = m_owner_valid && (m_owner_id == 2'(id));
    e.id       = 2'(id);
    e.err      = 1'b1;
    e.data     = '0;
    exp_strobe = 1'b0;
    exp_din    = '0;
    case (op)
      2'b01: if (!m_owner_valid || is_owner) begin
        e.err = 1'b0; exp_strobe = 1'b1; exp_din = wd;
        m_owner_valid = 1'b1; m_owner_id = 2'(id);
      end
      2'b00: if (is_owner) begin
        e.err = 1'b0; e.data = m_ready ? m_mem : 8'h00;
      end
      2'b10: if (is_owner) begin
        e.err = 1'b0; exp_strobe = 1'b1; exp_din = 8'h00;
        m_owner_valid = 1'b0; m_owner_id = '0;
      end
      default: ;
    endcase
    if (exp_strobe) begin
      m_mem   = exp_din;
      m_ready = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, output bit got);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (gnt != '0) got = 1'b1;
    end
    n_checks++;
    assert (got) else begin
      n_fail++;
      $error("[TB] FAIL %s_timeout observed=no_gnt expected=gnt", tag);
    end
  endtask

  // One complete op from a single requester: grant, strobe, response and ownership.
  task automatic apply_stimulus(input string tag, input int id, input logic [1:0] op, input logic [7:0] wd);
    logic       es;
    logic [7:0] ed;
    bit         got;
    @(negedge clk);
    req                  = '0;
    req[id]              = 1'b1;
    req_op[2*id +: 2]    = op;
    req_wdata[8*id +: 8] = wd;
    predict(id, op, wd, es, ed);
    wait_gnt(tag, got);
    check_output({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
    check_output({tag, "_strobe"}, 32'(store_data_valid), 32'(es));
    if (es) check_output({tag, "_din"}, 32'(store_data_in), 32'(ed));
    req = '0;
    @(negedge clk);
    check_output({tag, "_owner_valid"}, 32'(owner_valid), 32'(m_owner_valid));
    check_output({tag, "_owner_id"}, 32'(owner_id), 32'(m_owner_id));
    check_output({tag, "_storage"}, 32'(store_data_out), 32'(m_mem));
  endtask

  // Scoreboard side: every response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("[TB] FAIL unexpected_rsp observed=rsp_id_%0d expected=no_response", rsp_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("rsp_id", 32'(rsp_id), 32'(e.id));
        check_output("rsp_err", 32'(rsp_err), 32'(e.err));
        check_output("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         got;
    int         seq[5];
    int         n;
    int         cyc;
    int         last;
    logic       es;
    logic [7:0] ed;

    seq = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '0; req_op = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("reset_gnt", 32'(gnt), 0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 0);
    check_output("reset_rsp_id", 32'(rsp_id), 0);
    check_output("reset_rsp_data", 32'(rsp_data), 0);
    check_output("reset_rsp_err", 32'(rsp_err), 0);
    check_output("reset_store_valid", 32'(store_data_valid), 0);
    check_output("reset_store_in", 32'(store_data_in), 0);
    check_output("reset_owner_valid", 32'(owner_valid), 0);
    check_output("reset_owner_id", 32'(owner_id), 0);
    rst = 1'b0;

    // All four requesters reading at once; grants must rotate every 3 cycles.
    @(negedge clk);
    req = 4'b1111; req_op = '0;
    n = 0; cyc = 0; last = 0;
    while (n < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        check_output("rr_gnt", 32'(gnt), 32'(4'b0001 << seq[n]));
        if (n > 0) check_output("rr_spacing", cyc - last, 3);
        last = cyc;
        predict(seq[n], 2'b00, 8'h00, es, ed);
        n++;
        if (n == 5) req = '0;
      end
    end
    check_output("rr_grant_count", n, 5);
    @(negedge clk);

    apply_stimulus("w0_a5", 0, 2'b01, 8'hA5);
    apply_stimulus("r1_denied", 1, 2'b00, 8'h00);
    apply_stimulus("w1_denied", 1, 2'b01, 8'h3C);
    apply_stimulus("r0_owner", 0, 2'b00, 8'h00);
    apply_stimulus("resv2", 2, 2'b11, 8'hFF);
    apply_stimulus("w0_5a", 0, 2'b01, 8'h5A);
    apply_stimulus("r0_5a", 0, 2'b00, 8'h00);
    apply_stimulus("rel0", 0, 2'b10, 8'h00);
    apply_stimulus("r0_after_rel", 0, 2'b00, 8'h00);
    apply_stimulus("rel2_unowned", 2, 2'b10, 8'h00);

    // Reset during the GRANT cycle of a write aborts it with no response.
    @(negedge clk);
    req = 4'b0001; req_op[1:0] = 2'b01; req_wdata[7:0] = 8'h77;
    wait_gnt("abort", got);
    check_output("abort_gnt", 32'(gnt), 32'(4'b0001));
    check_output("abort_strobe", 32'(store_data_valid), 1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check_output("abort_gnt_clr", 32'(gnt), 0);
    check_output("abort_strobe_clr", 32'(store_data_valid), 0);
    check_output("abort_rsp_valid", 32'(rsp_valid), 0);
    check_output("abort_owner_valid", 32'(owner_valid), 0);
    check_output("abort_owner_id", 32'(owner_id), 0);
    rst = 1'b0;
    model_reset();

    // Pointer must be back at 0: requesters 0 and 3 together pick 0.
    @(negedge clk);
    req = 4'b1001; req_op = '0;
    predict(0, 2'b00, 8'h00, es, ed);
    wait_gnt("ptr_reset", got);
    check_output("ptr_reset_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    repeat (4) @(negedge clk);
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/secure_storage_arbiter.md
Name: secure_storage_arbiter

Overview:
- Shares one secure_data_storage style 8-bit register between NUM_REQ requesters using round-robin arbitration.
- Enforces single-owner access control:
  - The first requester to write becomes owner.
  - Only the owner may read, overwrite or release.
  - Release scrubs the stored value to zero.
- Sits between requester agents and the storage block, and drives the storage's data_valid/data_in write strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, storage data width.
- ID_W, 2, width of owner_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until the matching gnt bit is seen.
- req_op  input  2*NUM_REQ  per-requester op, slice [2i+1:2i]: 00 read, 01 write, 10 release, 11 reserved.
- req_wdata  input  NUM_REQ*DATA_W  per-requester write data, slice i.
- gnt  output  NUM_REQ  one-hot grant, single-cycle pulse.
- rsp_valid  output  1  response strobe, single cycle.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_data  output  DATA_W  read data; zero unless an authorised read.
- rsp_err  output  1  access denied or reserved op.
- store_data_in  output  DATA_W  write data to storage.
- store_data_valid  output  1  storage write strobe, single cycle.
- store_data_out  input  DATA_W  current storage contents.
- store_data_ready  input  1  storage holds valid data.
- owner_valid  output  1  storage currently owned.
- owner_id  output  ID_W  current owner; 0 when unowned.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - All outputs go to 0, including gnt, rsp_*, store_*, owner_valid and owner_id.
  - Asserting rst in any state aborts the operation in flight; no response is issued for it.
- FSM states: IDLE -> GRANT -> RESP -> IDLE. Exactly one operation is in flight at a time.
- IDLE:
  - If any req bit is high, select the first asserted requester searching from pointer upward, wrapping at NUM_REQ-1 -> 0.
  - Latch the selected index, its op and its wdata; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (cycle T+1 after selection in cycle T):
  - gnt[sel]=1 for this one cycle.
  - pointer <= (sel+1) mod NUM_REQ.
  - Evaluate the op against ownership state as it was before this op:
    - Write, unowned: store_data_valid=1, store_data_in=wdata, owner_valid<=1, owner_id<=sel, err=0.
    - Write by owner: store_data_valid=1, store_data_in=wdata, err=0.
    - Write by non-owner: no strobe, err=1.
    - Read by owner: err=0; data is taken in RESP.
    - Read by non-owner or while unowned: err=1.
    - Release by owner: store_data_valid=1, store_data_in=0 (scrub), owner_valid<=0, owner_id<=0, err=0.
    - Release by non-owner or while unowned: err=1, no effect.
    - Reserved op (11): err=1, no effect.
- RESP (cycle T+2):
  - rsp_valid=1 and rsp_id=sel.
  - rsp_err reflects the GRANT decision.
  - rsp_data=store_data_out only for an authorised read while store_data_ready=1; otherwise 0.
  - An authorised read with store_data_ready=0 returns data 0 with err=0.
  - A read in RESP immediately after a write therefore returns the newly written value, because the storage registered it at the end of GRANT.
  - Return to IDLE; the next arbitration happens in that IDLE cycle. Maximum throughput is one op per 3 cycles.
- Requester handshake:
  - Requesters sample gnt and may drop req or change op in the cycle after gnt.
  - A req still high in the IDLE cycle following its own grant is treated as a new request.
- Simultaneous requests: only one grant per arbitration. Losing requesters keep req high and are served in round-robin order; no starvation, worst-case wait (NUM_REQ-1) ops.
- Rejected accesses never alter storage, ownership or the pointer update rule; the pointer still advances.
- Unused high bits of owner_id and rsp_id are driven 0.

Test Plan:
- Reset, then req=0001 op0=write wdata0=0xA5 -> gnt=0001 at T+1, store_data_valid=1, store_data_in=0xA5; at T+2 rsp_valid=1, rsp_id=0, rsp_err=0; owner_valid=1, owner_id=0.
- Owner 0 holds 0xA5; req1 read -> rsp_err=1, rsp_data=0x00. Then req1 write 0x3C -> rsp_err=1, no store_data_valid, storage still 0xA5.
- Owner 0 read -> rsp_data=0xA5, rsp_err=0. Owner 0 release -> store_data_valid=1, store_data_in=0x00, owner_valid=0. Subsequent req0 read -> rsp_err=1.
- req=1111 held with all reads, starting from pointer 0 -> grants 0001, 0010, 0100, 1000, 0001 in order, one every 3 cycles.
- Assert rst in the GRANT cycle of a write -> next cycle all outputs 0, owner_valid=0, no rsp_valid, pointer 0.
- Reserved op=11 from req2 -> rsp_err=1, rsp_id=2, rsp_data=0, ownership and storage unchanged.
